// File: rtl/sim_finish_ctrl.sv
// End-of-program detector: tohost store, jal x0,0 self-loop or watchdog halts the core,
// then after DRAIN_CYCLES more edges raises a sticky finish_flag with cause, exit code and counts.
module sim_finish_ctrl #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_03FC,
  parameter int          SELFLOOP_REPS  = 4,
  parameter int          DRAIN_CYCLES   = 3,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic             halt,
  output logic             finish_flag,
  output logic             timeout_flag,
  output logic [1:0]       cause,
  output logic [31:0]      exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);
  localparam int SW = $clog2(SELFLOOP_REPS + 1);
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [31:0]      JAL_SELF   = 32'h0000_006F;
  localparam logic [SW-1:0]    SL_TARGET  = SW'(SELFLOOP_REPS);
  localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] sl_cnt, sl_cnt_n;
  logic [31:0]   sl_pc, sl_pc_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic          is_loop, t1, t2, t3;
  logic          halt_n, finish_n, timeout_n;
  logic [1:0]    cause_n;
  logic [31:0]   exit_n;

  always_comb begin
    is_loop  = instr_valid && (instr == JAL_SELF);
    sl_cnt_n = sl_cnt;
    sl_pc_n  = sl_pc;
    // A loop retirement at a new PC restarts the run rather than clearing it.
    if (instr_valid) begin
      if (!is_loop) begin
        sl_cnt_n = '0;
      end else if ((sl_cnt != '0) && (pc == sl_pc)) begin
        sl_cnt_n = sl_cnt + 1'b1;
      end else begin
        sl_cnt_n = SW'(1);
        sl_pc_n  = pc;
      end
    end

    t1 = mem_we && (mem_addr == TOHOST_ADDR);
    t2 = is_loop && (sl_cnt_n == SL_TARGET);
    t3 = (cycle_count == TO_LAST);

    state_n     = state;
    drain_cnt_n = drain_cnt;
    halt_n      = halt;
    finish_n    = finish_flag;
    timeout_n   = timeout_flag;
    cause_n     = cause;
    exit_n      = exit_code;

    case (state)
      RUN: begin
        if (t1 || t2 || t3) begin
          halt_n      = 1'b1;
          timeout_n   = !t1 && !t2;
          cause_n     = t1 ? 2'd1 : (t2 ? 2'd2 : 2'd3);
          exit_n      = t1 ? mem_wdata : 32'h0;
          drain_cnt_n = DRAIN_INIT;
          if (DRAIN_CYCLES == 0) begin
            state_n  = DONE;
            finish_n = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_cnt_n = drain_cnt - 1'b1;
        if (drain_cnt == DW'(1)) begin
          state_n  = DONE;
          finish_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      sl_cnt        <= '0;
      sl_pc         <= '0;
      drain_cnt     <= '0;
      halt          <= 1'b0;
      finish_flag   <= 1'b0;
      timeout_flag  <= 1'b0;
      cause         <= 2'd0;
      exit_code     <= 32'h0;
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      state        <= state_n;
      drain_cnt    <= drain_cnt_n;
      halt         <= halt_n;
      finish_flag  <= finish_n;
      timeout_flag <= timeout_n;
      cause        <= cause_n;
      exit_code    <= exit_n;
      // Counters include the trigger cycle and freeze once the core halts.
      if (state == RUN) begin
        cycle_count <= cycle_count + 1'b1;
        if (instr_valid) retired_count <= retired_count + 1'b1;
        sl_cnt <= sl_cnt_n;
        sl_pc  <= sl_pc_n;
      end
    end
  end
endmodule

// File: tb/tb_sim_finish_ctrl.sv
// Bench for sim_finish_ctrl: per-cycle stimulus tables, a trace-level reference model feeding an
// expected-finish queue, and a monitor that checks each finish event and the held DONE outputs.
`timescale 1ns/1ps
module tb_sim_finish_ctrl;
  localparam logic [31:0] TOHOST = 32'h0000_03FC;
  localparam int REPS  = 4;
  localparam int DRAIN = 3;
  localparam int TMO   = 50;
  localparam int LEN   = 64;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc = '0, instr = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        halt, finish_flag, timeout_flag;
  logic [1:0]  cause;
  logic [31:0] exit_code, cycle_count, retired_count;

  sim_finish_ctrl #(
    .TOHOST_ADDR(TOHOST), .SELFLOOP_REPS(REPS), .DRAIN_CYCLES(DRAIN),
    .TIMEOUT_CYCLES(TMO), .CNT_W(32)
  ) dut (
    .clock(clock), .rst(rst), .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .halt(halt), .finish_flag(finish_flag), .timeout_flag(timeout_flag), .cause(cause),
    .exit_code(exit_code), .cycle_count(cycle_count), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic v; logic [31:0] pc; logic [31:0] instr; logic we; logic [31:0] addr; logic [31:0] data;
  } stim_t;
  typedef struct {
    logic [1:0] cause; logic [31:0] exit_code; logic tmo;
    int cyc; int ret; int halt_edge; int fin_edge;
  } exp_t;

  stim_t st[LEN];
  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    edge_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Edges since reset release; edge 1 samples stimulus cycle 0.
  always @(posedge clock or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  exp_t cur;
  bit   have_cur = 0;
  bit   halt_q = 0, fin_q = 0;
  int   halt_edge = -1;

  always @(negedge clock) begin
    if (!rst) begin
      halt_q = 0; fin_q = 0; halt_edge = -1; have_cur = 0;
    end else begin
      if (halt && !halt_q) halt_edge = edge_cnt;
      if (finish_flag && !fin_q) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_finish: finish_flag=1 at edge %0d, expected none", edge_cnt);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          chk("finish_edge", 64'(edge_cnt), 64'(cur.fin_edge));
          chk("halt_edge", 64'(halt_edge), 64'(cur.halt_edge));
          chk("cause", 64'(cause), 64'(cur.cause));
          chk("exit_code", 64'(exit_code), 64'(cur.exit_code));
          chk("timeout_flag", 64'(timeout_flag), 64'(cur.tmo));
          chk("cycle_count", 64'(cycle_count), 64'(cur.cyc));
          chk("retired_count", 64'(retired_count), 64'(cur.ret));
        end
      end else if (finish_flag && have_cur) begin
        chk("done_exit_code", 64'(exit_code), 64'(cur.exit_code));
        chk("done_cause", 64'(cause), 64'(cur.cause));
        chk("done_halt", 64'(halt), 64'd1);
      end
      halt_q = halt;
      fin_q  = finish_flag;
    end
  end

  task automatic apply(input stim_t s);
    instr_valid = s.v; pc = s.pc; instr = s.instr;
    mem_we = s.we; mem_addr = s.addr; mem_wdata = s.data;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_halt"}, 64'(halt), 64'd0);
    chk({tag, "_finish"}, 64'(finish_flag), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_flag), 64'd0);
    chk({tag, "_cause"}, 64'(cause), 64'd0);
    chk({tag, "_exit"}, 64'(exit_code), 64'd0);
    chk({tag, "_cycles"}, 64'(cycle_count), 64'd0);
    chk({tag, "_retired"}, 64'(retired_count), 64'd0);
  endtask

  task automatic clear_stim();
    for (int c = 0; c < LEN; c++) begin
      st[c].v = 1'b1; st[c].pc = 32'h100 + 32'(c * 4); st[c].instr = NOP;
      st[c].we = 1'b0; st[c].addr = '0; st[c].data = '0;
    end
  endtask

  task automatic store(input int c, input logic [31:0] a, input logic [31:0] d);
    st[c].we = 1'b1; st[c].addr = a; st[c].data = d;
  endtask

  task automatic loop_at(input int c, input logic [31:0] p);
    st[c].v = 1'b1; st[c].instr = JAL; st[c].pc = p;
  endtask

  // Walks the trace cycle by cycle: the first cycle where any finish rule holds decides everything.
  task automatic model(input bit push, output int t);
    int run_len, ret;
    logic [31:0] lpc;
    bit t1, t2, t3;
    exp_t e;
    run_len = 0; ret = 0; lpc = '0; t = -1;
    for (int c = 0; c < LEN; c++) begin
      if (st[c].v) ret++;
      t1 = st[c].we && (st[c].addr == TOHOST);
      t2 = 0;
      if (st[c].v && st[c].instr == JAL) begin
        run_len = (run_len > 0 && st[c].pc == lpc) ? run_len + 1 : 1;
        lpc = st[c].pc;
        t2 = (run_len == REPS);
      end else if (st[c].v) begin
        run_len = 0;
      end
      t3 = (c == TMO - 1);
      if (t1 || t2 || t3) begin
        e.cause     = t1 ? 2'd1 : (t2 ? 2'd2 : 2'd3);
        e.exit_code = t1 ? st[c].data : 32'h0;
        e.tmo       = !t1 && !t2;
        e.cyc       = c + 1;
        e.ret       = ret;
        e.halt_edge = c + 1;
        e.fin_edge  = c + 1 + DRAIN;
        if (push) exp_q.push_back(e);
        t = c;
        break;
      end
    end
  endtask

  task automatic run(input int n, input int rst_at);
    stim_t idle;
    idle.v = 0; idle.pc = '0; idle.instr = '0; idle.we = 0; idle.addr = '0; idle.data = '0;
    rst = 1'b0;
    apply(idle);
    repeat (2) @(negedge clock);
    check_zero("reset");
    rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      apply(st[c]);
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1 check_zero("abort");
        break;
      end
      @(negedge clock);
    end
    if (rst_at < 0) begin
      chk("finish_seen", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic rand_stim(input int mode);
    logic [31:0] lp;
    int r;
    lp = 32'h40;
    for (int c = 0; c < LEN; c++) begin
      st[c].v = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) lp = (lp == 32'h40) ? 32'h44 : 32'h40;
      st[c].pc = lp;
      r = $urandom_range(3);
      if (r <= 1) st[c].instr = (mode == 1 || mode == 3) ? NOP : JAL;
      else if (r == 2) st[c].instr = NOP;
      else st[c].instr = $urandom;
      st[c].we = ($urandom_range(7) == 0);
      r = $urandom_range(7);
      if (r == 0) st[c].addr = (mode == 2 || mode == 3) ? TOHOST + 32'd4 : TOHOST;
      else if (r == 1) st[c].addr = TOHOST ^ (32'h1 << $urandom_range(31));
      else st[c].addr = $urandom & 32'hFFFF_FFFC;
      st[c].data = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // tohost at cycle 20
    clear_stim(); store(20, TOHOST, 32'h1);
    model(1, t); run(t + DRAIN + 4, -1);
    // four consecutive self-loop retirements
    clear_stim(); for (int c = 5; c <= 8; c++) loop_at(c, 32'h40);
    model(1, t); run(t + DRAIN + 4, -1);
    // broken loop, with an idle cycle holding the count
    clear_stim();
    for (int c = 2; c <= 4; c++) loop_at(c, 32'h40);
    st[5].instr = ADDI;
    loop_at(6, 32'h40); st[7].v = 1'b0; loop_at(8, 32'h40); loop_at(9, 32'h40); loop_at(10, 32'h40);
    model(1, t); run(t + DRAIN + 4, -1);
    // watchdog
    clear_stim();
    model(1, t); run(t + DRAIN + 4, -1);
    // tohost and 4th loop in one cycle, then stores during drain and done
    clear_stim(); for (int c = 3; c <= 6; c++) loop_at(c, 32'h40);
    store(6, TOHOST, 32'hCAFE_F00D); store(8, TOHOST, 32'h7); store(11, TOHOST, 32'h7);
    model(1, t); run(t + DRAIN + 4, -1);
    // reset mid-drain, then a fresh run
    clear_stim(); store(10, TOHOST, 32'h55);
    model(0, t); run(t + DRAIN + 4, 12);
    clear_stim(); store(5, TOHOST, 32'h99);
    model(1, t); run(t + DRAIN + 4, -1);
    for (int i = 0; i < 40; i++) begin
      rand_stim(i % 4);
      model(1, t); run(t + DRAIN + 4, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
